// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, issues in-order requests to a variable
// latency instruction memory, buffers responses in a small in-order queue and
// drives the IF/ID register. Redirects from execute clear the queue and any
// responses still in flight are counted and discarded on arrival.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   PCSrcE, PCTargetE   redirect request / target from execute
//   StallD, FlushD      hold / invalidate the IF/ID register
//   IMemReq, IMemAddr   fetch request valid / address (always PCF)
//   IMemGnt             request accepted this cycle
//   IMemValid, IMemRData in-order response valid / instruction
//   InstrD, PCD, PCPlus4D, ValidD  IF/ID register outputs
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemGnt,
    input  logic            IMemValid,
    input  logic [31:0]     IMemRData,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;   // counters must reach DEPTH
    localparam int unsigned SW = CW + 1;   // headroom for occ + drop sum

    logic [XLEN-1:0]  pcf_q, pcf_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, fill_ptr_q, fill_ptr_d;
    logic [CW-1:0]    occ_q, occ_d, unf_q, unf_d, drop_q, drop_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [XLEN-1:0]  ent_pc_q    [DEPTH];
    logic [31:0]      ent_instr_q [DEPTH];

    logic [31:0]      instrd_q, instrd_d;
    logic [XLEN-1:0]  pcd_q, pcd_d, pcp4d_q, pcp4d_d;
    logic             validd_q, validd_d;

    logic             head_filled_c, pop_c, acc_c, resp_fill_c, resp_drop_c;
    logic [SW-1:0]    credit_c;

    // Handshake decode; a same-cycle pop frees one credit for the request.
    always_comb begin
        head_filled_c = (occ_q != '0) && filled_q[rd_ptr_q];
        pop_c         = head_filled_c && !StallD && !PCSrcE && !FlushD;
        credit_c      = SW'(occ_q) + SW'(drop_q) - SW'(pop_c);
        IMemReq       = reset && !PCSrcE && (credit_c < SW'(DEPTH));
        acc_c         = IMemReq && IMemGnt;
        // Responses with nothing outstanding fall through both terms (ignored).
        resp_fill_c   = IMemValid && (drop_q == '0) && (unf_q != '0);
        resp_drop_c   = IMemValid && (drop_q != '0);
    end

    // Next-state: PC, queue bookkeeping, drop counter and IF/ID register.
    always_comb begin
        pcf_d      = pcf_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        occ_d      = occ_q;
        unf_d      = unf_q;
        drop_d     = drop_q;
        filled_d   = filled_q;
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcp4d_d    = pcp4d_q;
        validd_d   = validd_q;

        if (PCSrcE) begin
            pcf_d      = PCTargetE;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            occ_d      = '0;
            unf_d      = '0;
            filled_d   = '0;
            // Every unfilled entry becomes a response to throw away.
            drop_d     = drop_q + unf_q - CW'(resp_fill_c) - CW'(resp_drop_c);
        end else begin
            if (acc_c) begin
                pcf_d              = pcf_q + XLEN'(4);
                wr_ptr_d           = wr_ptr_q + PW'(1);
                filled_d[wr_ptr_q] = 1'b0;
            end
            if (resp_fill_c) begin
                fill_ptr_d           = fill_ptr_q + PW'(1);
                filled_d[fill_ptr_q] = 1'b1;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occ_d  = occ_q + CW'(acc_c) - CW'(pop_c);
            unf_d  = unf_q + CW'(acc_c) - CW'(resp_fill_c);
            drop_d = drop_q - CW'(resp_drop_c);
        end

        if (PCSrcE || FlushD) begin
            validd_d = 1'b0;
            instrd_d = NOP;
        end else if (StallD) begin
            validd_d = validd_q;
        end else if (pop_c) begin
            validd_d = 1'b1;
            instrd_d = ent_instr_q[rd_ptr_q];
            pcd_d    = ent_pc_q[rd_ptr_q];
            pcp4d_d  = ent_pc_q[rd_ptr_q] + XLEN'(4);
        end else begin
            validd_d = 1'b0;
            instrd_d = NOP;
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcf_q      <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            occ_q      <= '0;
            unf_q      <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
            instrd_q   <= NOP;
            pcd_q      <= '0;
            pcp4d_q    <= '0;
            validd_q   <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            occ_q      <= occ_d;
            unf_q      <= unf_d;
            drop_q     <= drop_d;
            filled_q   <= filled_d;
            instrd_q   <= instrd_d;
            pcd_q      <= pcd_d;
            pcp4d_q    <= pcp4d_d;
            validd_q   <= validd_d;
        end
    end

    // Queue payload; validity is tracked by occ/filled so no reset is needed.
    always_ff @(posedge clk) begin
        if (acc_c) begin
            ent_pc_q[wr_ptr_q] <= pcf_q;
        end
        if (resp_fill_c && !PCSrcE) begin
            ent_instr_q[fill_ptr_q] <= IMemRData;
        end
    end

    assign IMemAddr = pcf_q;
    assign InstrD   = instrd_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4d_q;
    assign ValidD   = validd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus an in-order memory
// responder with programmable latency; directed phases with literal anchors.
module tb_fetch_stage;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOPI  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrcE = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        IMemReq, IMemGnt = 1'b0, IMemValid = 1'b0, ValidD;
    logic [31:0] IMemAddr, IMemRData = '0, InstrD, PCD, PCPlus4D;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH), .NOP(NOPI)) dut (
        .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemGnt(IMemGnt), .IMemValid(IMemValid), .IMemRData(IMemRData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
    typedef struct { logic [31:0] pc; int due; } rsp_t;

    ent_t        mq[$];
    rsp_t        rq[$];
    logic [31:0] m_pcf, m_instr, m_pcd, m_pcp4;
    bit          m_valid;
    int          m_drop;
    int          cyc = 0, lat = 1;
    bit          gnt_en = 1'b0, ghost = 1'b0;
    int          errors = 0, checks = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] pc);
        return pc ^ 32'hA500_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rq.delete();
        m_pcf = 32'h0; m_drop = 0;
        m_valid = 1'b0; m_instr = NOPI; m_pcd = '0; m_pcp4 = '0;
    endtask

    // One clock cycle: drive inputs, compare all outputs, advance the model.
    task automatic step(input bit st, input bit fl, input bit ps, input logic [31:0] tgt);
        bit pop, req, acc, rv;
        logic [31:0] rd;
        int unf, fi, due;
        @(negedge clk);
        StallD = st; FlushD = fl; PCSrcE = ps; PCTargetE = tgt; IMemGnt = gnt_en;
        rv = 1'b0; rd = 32'hDEAD_BEEF;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            rv = 1'b1; rd = mem_f(rq[0].pc); void'(rq.pop_front());
        end else if (ghost) begin
            rv = 1'b1;
        end
        IMemValid = rv; IMemRData = rd;
        #1;
        pop = mq.size() > 0 && mq[0].filled && !st && !fl && !ps;
        req = !ps && (mq.size() + m_drop - int'(pop) < DEPTH);
        acc = req && gnt_en;
        chk("IMemReq", 32'(IMemReq), 32'(req));
        chk("IMemAddr", IMemAddr, m_pcf);
        chk("ValidD", 32'(ValidD), 32'(m_valid));
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pcp4);

        if (ps || fl) begin
            m_valid = 1'b0; m_instr = NOPI;
        end else if (!st) begin
            if (pop) begin
                m_valid = 1'b1; m_instr = mq[0].instr; m_pcd = mq[0].pc; m_pcp4 = mq[0].pc + 32'd4;
            end else begin
                m_valid = 1'b0; m_instr = NOPI;
            end
        end

        unf = 0; fi = -1;
        foreach (mq[i]) if (!mq[i].filled) begin
            unf++;
            if (fi < 0) fi = i;
        end
        if (ps) begin
            m_drop = m_drop + unf - ((rv && (unf > 0 || m_drop > 0)) ? 1 : 0);
            mq.delete();
            m_pcf = tgt;
        end else begin
            if (rv) begin
                if (m_drop > 0) m_drop--;
                else if (fi >= 0) begin mq[fi].filled = 1'b1; mq[fi].instr = rd; end
            end
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{pc: m_pcf, instr: 32'h0, filled: 1'b0});
                due = cyc + lat;
                if (rq.size() > 0 && rq[rq.size()-1].due > due) due = rq[rq.size()-1].due;
                rq.push_back('{pc: m_pcf, due: due});
                m_pcf = m_pcf + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        gnt_en = 1'b0;
        run(8);
        gnt_en = 1'b1;
    endtask

    // Bounded wait for the next valid instruction, then pin its PC.
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (ValidD) seen = 1'b1;
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk(name, PCD, exp_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_ValidD", 32'(ValidD), 32'd0);
        chk("rst_InstrD", InstrD, 32'h13);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_IMemReq", 32'(IMemReq), 32'd0);
        chk("rst_IMemAddr", IMemAddr, 32'h0);
        @(posedge clk); @(posedge clk); #2 reset = 1'b1;

        // Zero-wait stream: first instruction reaches D after edge 2.
        gnt_en = 1'b1; lat = 1;
        run(3);
        chk("lat_not_yet", 32'(ValidD), 32'd0);
        run(1);
        chk("first_valid", 32'(ValidD), 32'd1);
        chk("first_pcd", PCD, 32'h0);
        chk("first_instr", InstrD, 32'hA500_0000);
        run(1);
        chk("second_pcd", PCD, 32'h4);
        chk("second_pcp4", PCPlus4D, 32'h8);
        run(1);
        chk("third_pcd", PCD, 32'h8);

        // Grant withheld for three cycles; stray response with nothing outstanding.
        gnt_en = 1'b0; ghost = 1'b1;
        run(3);
        gnt_en = 1'b1; ghost = 1'b0;
        run(8);

        // Five-cycle latency: four outstanding then requests stop until a pop.
        drain();
        lat = 5;
        run(4);
        chk("lat5_req_c3", 32'(IMemReq), 32'd1);
        run(1);
        chk("lat5_req_c4", 32'(IMemReq), 32'd0);
        run(1);
        chk("lat5_req_c5", 32'(IMemReq), 32'd0);
        run(1);
        chk("lat5_req_c6", 32'(IMemReq), 32'd1);
        run(15);

        // Stall mid-stream: queue fills to four then requesting stops.
        drain();
        lat = 1;
        run(4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_full_req", 32'(IMemReq), 32'd0);
        run(6);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        run(4);

        // Redirect with three in flight and one response in the same cycle.
        drain();
        lat = 3;
        run(3);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        run(1);
        chk("redir_bubble", 32'(ValidD), 32'd0);
        wait_valid("redir_pcd", 32'h100);
        run(1);
        chk("redir_next_pcd", PCD, 32'h104);
        run(6);

        // Wraparound of PC arithmetic.
        drain();
        lat = 1;
        run(4);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        wait_valid("wrap_pcd0", 32'hFFFF_FFF8);
        chk("wrap_pcp4_0", PCPlus4D, 32'hFFFF_FFFC);
        run(1);
        chk("wrap_pcd1", PCD, 32'hFFFF_FFFC);
        chk("wrap_pcp4_1", PCPlus4D, 32'h0);
        run(1);
        chk("wrap_pcd2", PCD, 32'h0);
        chk("wrap_pcp4_2", PCPlus4D, 32'h4);

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        #2 reset = 1'b0;
        #1;
        chk("async_ValidD", 32'(ValidD), 32'd0);
        chk("async_IMemReq", 32'(IMemReq), 32'd0);
        chk("async_PCD", PCD, 32'h0);
        chk("async_IMemAddr", IMemAddr, 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #2 reset = 1'b1;
        run(4);
        chk("restart_pcd", PCD, 32'h0);
        chk("restart_valid", 32'(ValidD), 32'd1);
        run(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
